// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer: default widths,
// exception handler address, exception codes and the stage-entry layout.
package pipe_pkg;

   localparam int          PC_W_DEF       = 32;
   localparam int          DATA_W_DEF     = 96;
   localparam int          EXC_W_DEF      = 5;
   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

   // Exception cause codes carried alongside each entry
   localparam logic [EXC_W_DEF-1:0] EXC_NONE = 5'd0;
   localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W_DEF-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W_DEF-1:0] EXC_SYS  = 5'd8;
   localparam logic [EXC_W_DEF-1:0] EXC_BP   = 5'd9;
   localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

   // Canonical stage-entry layout at the default widths
   typedef struct packed {
      logic [PC_W_DEF-1:0]   pc;
      logic                  bd;
      logic [EXC_W_DEF-1:0]  exc;
      logic [DATA_W_DEF-1:0] data;
      logic                  bubble;
   } stage_entry_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on inc until all-ones, clear has priority
   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: two-entry skid buffer (main + skid) with
// exception redirect and bubble insertion. Optional performance counters
// are built when PIPE_STAGE_BUF_PERF_EN is defined.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int          DATA_W     = DATA_W_DEF,
   parameter int          PC_W       = PC_W_DEF,
   parameter int          EXC_W      = EXC_W_DEF,
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
   parameter int          CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_bd,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_bd,
   output logic [EXC_W-1:0]  out_exc,
   output logic [DATA_W-1:0] out_data,
   output logic              out_bubble,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Same layout as pipe_pkg::stage_entry_t, sized by this instance
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic              bd;
      logic [EXC_W-1:0]  exc;
      logic [DATA_W-1:0] data;
      logic              bubble;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;
   entry_t main_p0;
   entry_t skid_p0;
   logic   vld_p0;
   logic   rdy_p0;
   entry_t in_entry;
   logic   push;
   logic   pop;

   function automatic entry_t flush_bubble(input logic [PC_W-1:0] pc,
                                           input logic bd,
                                           input logic [EXC_W-1:0] exc);
      entry_t e;
      e.pc     = pc;
      e.bd     = bd;
      e.exc    = exc;
      e.data   = '0;
      e.bubble = 1'b1;
      return e;
   endfunction

   function automatic entry_t handler_bubble();
      return flush_bubble(PC_W'(HANDLER_PC), 1'b0, EXC_W'(EXC_NONE));
   endfunction

   assign in_entry = '{pc: in_pc, bd: in_bd, exc: in_exc, data: in_data, bubble: 1'b0};
   assign push     = in_valid & rdy_p0;
   assign pop      = vld_p0 & out_ready;

   // Buffer FSM: reset > req > flush > push/pop, all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= EMPTY;
         main_p0 <= '0;
         skid_p0 <= '0;
         vld_p0  <= 1'b0;
         rdy_p0  <= 1'b1;
      end else if (req) begin
         state   <= ONE;
         main_p0 <= handler_bubble();
         skid_p0 <= '0;
         vld_p0  <= 1'b1;
         rdy_p0  <= 1'b1;
      end else if (flush) begin
         skid_p0 <= '0;
         rdy_p0  <= 1'b1;
         if (in_valid) begin
            state   <= ONE;
            main_p0 <= flush_bubble(in_pc, in_bd, in_exc);
            vld_p0  <= 1'b1;
         end else begin
            state   <= EMPTY;
            vld_p0  <= 1'b0;
         end
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  state   <= ONE;
                  main_p0 <= in_entry;
                  vld_p0  <= 1'b1;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_p0 <= in_entry;
               end else if (push) begin
                  state   <= FULL;
                  skid_p0 <= in_entry;
                  rdy_p0  <= 1'b0;
               end else if (pop) begin
                  state   <= EMPTY;
                  vld_p0  <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  state   <= ONE;
                  main_p0 <= skid_p0;
                  rdy_p0  <= 1'b1;
               end
            end
            default: begin
               state  <= EMPTY;
               vld_p0 <= 1'b0;
               rdy_p0 <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready   = rdy_p0;
   assign out_valid  = vld_p0;
   assign out_pc     = main_p0.pc;
   assign out_bd     = main_p0.bd;
   assign out_exc    = main_p0.exc;
   assign out_data   = main_p0.data;
   assign out_bubble = main_p0.bubble;

`ifdef PIPE_STAGE_BUF_PERF_EN
   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (vld_p0 & ~out_ready),
      .count (stall_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (req | flush),
      .count (bubble_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (CNT_W=4).
module tb_pipe_stage_buf;

   localparam int DATA_W = 96;
   localparam int PC_W   = 32;
   localparam int EXC_W  = 5;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic              in_bd;
   logic [EXC_W-1:0]  in_exc;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic              out_bd;
   logic [EXC_W-1:0]  out_exc;
   logic [DATA_W-1:0] out_data;
   logic              out_bubble;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   int vectors = 0;
   int miscompares = 0;

`ifdef PIPE_STAGE_BUF_PERF_EN
   localparam logic [127:0] EXP_STALL_SAT = 128'd15;
   localparam logic [127:0] EXP_BUB_ONE   = 128'd1;
`else
   localparam logic [127:0] EXP_STALL_SAT = 128'd0;
   localparam logic [127:0] EXP_BUB_ONE   = 128'd0;
`endif

   pipe_stage_buf #(
      .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W),
      .HANDLER_PC(32'h0000_4180), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_bd(in_bd),
      .in_exc(in_exc), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_bd(out_bd),
      .out_exc(out_exc), .out_data(out_data), .out_bubble(out_bubble),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [95:0] d);
      in_valid = v;
      in_pc    = pc;
      in_data  = d;
      in_bd    = 1'b0;
      in_exc   = '0;
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 96'h0);
      step(); step();
      reset = 1'b0;

      // Reset state
      chk("rst_valid",  128'(out_valid),  128'd0);
      chk("rst_ready",  128'(in_ready),   128'd1);
      chk("rst_pc",     128'(out_pc),     128'd0);
      chk("rst_data",   128'(out_data),   128'd0);
      chk("rst_bubble", 128'(out_bubble), 128'd0);
      chk("rst_stall",  128'(stall_cnt),  128'd0);
      chk("rst_bcnt",   128'(bubble_cnt), 128'd0);

      // Single push, one-cycle latency
      drive(1'b1, 32'h3000, 96'hA5);
      step();
      chk("p1_valid",  128'(out_valid),  128'd1);
      chk("p1_pc",     128'(out_pc),     128'h3000);
      chk("p1_data",   128'(out_data),   128'hA5);
      chk("p1_ready",  128'(in_ready),   128'd1);
      chk("p1_bubble", 128'(out_bubble), 128'd0);
      drive(1'b0, 32'h0, 96'h0);
      step();
      chk("p1_drain", 128'(out_valid), 128'd0);

      // Fill to FULL under backpressure, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 32'h3000, 96'h1);
      step();
      drive(1'b1, 32'h3004, 96'h2);
      step();
      chk("full_ready", 128'(in_ready),  128'd0);
      chk("full_pc",    128'(out_pc),    128'h3000);
      chk("full_valid", 128'(out_valid), 128'd1);
      drive(1'b1, 32'h3008, 96'h3);
      step();
      chk("full_hold_pc",    128'(out_pc),   128'h3000);
      chk("full_hold_data",  128'(out_data), 128'h1);
      chk("full_hold_ready", 128'(in_ready), 128'd0);
      drive(1'b0, 32'h0, 96'h0);
      out_ready = 1'b1;
      step();
      chk("drain1_pc",    128'(out_pc),    128'h3004);
      chk("drain1_data",  128'(out_data),  128'h2);
      chk("drain1_valid", 128'(out_valid), 128'd1);
      chk("drain1_ready", 128'(in_ready),  128'd1);
      step();
      chk("drain2_valid", 128'(out_valid), 128'd0);

      // Streaming push+pop in ONE
      drive(1'b1, 32'h3060, 96'h60);
      step();
      drive(1'b1, 32'h3064, 96'h64);
      step();
      chk("stream_pc",    128'(out_pc),   128'h3064);
      chk("stream_data",  128'(out_data), 128'h64);
      chk("stream_ready", 128'(in_ready), 128'd1);
      drive(1'b0, 32'h0, 96'h0);
      step();
      chk("stream_drain", 128'(out_valid), 128'd0);

      // Flush with valid input inserts a bubble keeping pc/bd/exc
      out_ready = 1'b0;
      flush = 1'b1;
      drive(1'b1, 32'h3010, 96'hFFFF);
      in_bd = 1'b1; in_exc = 5'd4;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 96'h0);
      chk("fl_valid",  128'(out_valid),  128'd1);
      chk("fl_pc",     128'(out_pc),     128'h3010);
      chk("fl_bd",     128'(out_bd),     128'd1);
      chk("fl_exc",    128'(out_exc),    128'd4);
      chk("fl_data",   128'(out_data),   128'd0);
      chk("fl_bubble", 128'(out_bubble), 128'd1);
      out_ready = 1'b1;
      step();

      // req + flush in FULL: handler bubble, skid discarded
      out_ready = 1'b0;
      drive(1'b1, 32'h3020, 96'h20);
      step();
      drive(1'b1, 32'h3024, 96'h24);
      step();
      chk("rq_full_ready", 128'(in_ready), 128'd0);
      req = 1'b1; flush = 1'b1;
      drive(1'b1, 32'h3028, 96'h28);
      step();
      req = 1'b0; flush = 1'b0;
      drive(1'b0, 32'h0, 96'h0);
      chk("rq_pc",     128'(out_pc),     128'h4180);
      chk("rq_exc",    128'(out_exc),    128'd0);
      chk("rq_bd",     128'(out_bd),     128'd0);
      chk("rq_data",   128'(out_data),   128'd0);
      chk("rq_bubble", 128'(out_bubble), 128'd1);
      chk("rq_ready",  128'(in_ready),   128'd1);
      chk("rq_valid",  128'(out_valid),  128'd1);
      out_ready = 1'b1;
      step();
      chk("rq_no_skid", 128'(out_valid), 128'd0);

      // Reset while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h3030, 96'h30);
      step();
      drive(1'b1, 32'h3034, 96'h34);
      step();
      drive(1'b0, 32'h0, 96'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_valid",  128'(out_valid),  128'd0);
      chk("mr_ready",  128'(in_ready),   128'd1);
      chk("mr_pc",     128'(out_pc),     128'd0);
      chk("mr_bd",     128'(out_bd),     128'd0);
      chk("mr_exc",    128'(out_exc),    128'd0);
      chk("mr_data",   128'(out_data),   128'd0);
      chk("mr_bubble", 128'(out_bubble), 128'd0);
      chk("mr_stall",  128'(stall_cnt),  128'd0);
      out_ready = 1'b1;
      step();
      chk("mr_no_reappear", 128'(out_valid), 128'd0);

      // Flush without valid input empties the stage
      out_ready = 1'b0;
      drive(1'b1, 32'h3040, 96'h40);
      step();
      drive(1'b0, 32'h0, 96'h0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fe_valid", 128'(out_valid),  128'd0);
      chk("fe_ready", 128'(in_ready),   128'd1);
      chk("fe_bcnt",  128'(bubble_cnt), EXP_BUB_ONE);

      // Stall counter saturation over 20 backpressured cycles
      drive(1'b1, 32'h3050, 96'h50);
      step();
      drive(1'b0, 32'h0, 96'h0);
      for (int i = 0; i < 20; i++) step();
      chk("stall_sat", 128'(stall_cnt), EXP_STALL_SAT);
      chk("stall_pc",  128'(out_pc),    128'h3050);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
